// File: rtl/ddram_wr_arbiter_if.sv
// Signal bundle between the DDRAM write arbiter, its two requesters and the DDRAM pins.
// The arbiter connects through the slave modport; the environment connects through master.
interface ddram_wr_arbiter_if;
    // Rotate writer: fire-and-forget, one entry per cycle that r_we is high.
    logic        r_we;
    logic [28:0] r_addr;
    logic [63:0] r_din;
    logic [7:0]  r_be;
    logic        r_overflow;

    // Generic client: level request held until the one-cycle c_ack.
    logic        c_req;
    logic        c_rd;
    logic [28:0] c_addr;
    logic [63:0] c_din;
    logic [7:0]  c_be;
    logic        c_ack;
    logic [63:0] c_dout;

    // DDRAM command handshake: DDRAM_WE/DDRAM_RD are the valid strobe and !DDRAM_BUSY is
    // ready; a command transfers on a cycle where a strobe is high and BUSY is low, and
    // every command field stays stable from the first valid cycle until that transfer.
    logic        DDRAM_CLK;
    logic        DDRAM_BUSY;
    logic [7:0]  DDRAM_BURSTCNT;
    logic [28:0] DDRAM_ADDR;
    logic [63:0] DDRAM_DIN;
    logic [7:0]  DDRAM_BE;
    logic        DDRAM_WE;
    logic        DDRAM_RD;
    logic [63:0] DDRAM_DOUT;
    logic        DDRAM_DOUT_READY;

    modport slave (
        input  r_we, r_addr, r_din, r_be,
        output r_overflow,
        input  c_req, c_rd, c_addr, c_din, c_be,
        output c_ack, c_dout,
        output DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD,
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY
    );

    modport master (
        output r_we, r_addr, r_din, r_be,
        input  r_overflow,
        output c_req, c_rd, c_addr, c_din, c_be,
        input  c_ack, c_dout,
        input  DDRAM_CLK, DDRAM_BURSTCNT, DDRAM_ADDR, DDRAM_DIN, DDRAM_BE, DDRAM_WE, DDRAM_RD,
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY
    );
endinterface

// File: rtl/ddram_wr_arbiter.sv
// Shares one DDRAM port between a FIFO-buffered rotate pixel writer and a generic
// read/write client, with urgency override and round-robin arbitration.
module ddram_wr_arbiter #(
    parameter int FIFO_AW = 4,
    parameter int URGENT  = 8
) (
    input  logic              CLK_VIDEO,
    input  logic              reset,
    ddram_wr_arbiter_if.slave bus,
    output logic [1:0]        dbg_state
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    typedef enum logic {
        G_CLIENT = 1'b0,
        G_ROTATE = 1'b1
    } grant_t;

    typedef struct packed {
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } entry_t;

    // Rotate-write FIFO
    entry_t             mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   fill;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               overflow;
    entry_t             head;

    // Arbiter / command state
    state_t             state;
    grant_t             last_grant;
    logic               cur_client;
    logic [28:0]        cmd_addr;
    logic [63:0]        cmd_din;
    logic [7:0]         cmd_be;
    logic               cmd_we;
    logic               cmd_rd;
    logic               ack;
    logic [63:0]        dout;

    logic               r_pend;
    logic               c_pend;
    logic               grant_r;
    logic               grant_c;

    // fill never exceeds DEPTH, so its top bit alone marks a full FIFO.
    assign full  = fill[FIFO_AW];
    assign empty = (fill == '0);
    assign head  = mem[rd_ptr];

    always_comb begin
        r_pend  = !empty;
        // c_req is still high during the c_ack cycle; it must not start a second op.
        c_pend  = bus.c_req && !ack;
        grant_r = 1'b0;
        grant_c = 1'b0;
        if (state == IDLE) begin
            if (int'(fill) >= URGENT) begin
                grant_r = 1'b1;
            end else if (r_pend && c_pend) begin
                if (last_grant == G_CLIENT) grant_r = 1'b1;
                else                        grant_c = 1'b1;
            end else if (r_pend) begin
                grant_r = 1'b1;
            end else if (c_pend) begin
                grant_c = 1'b1;
            end
        end
    end

    // A pop on the grant cycle frees a slot, so a write arriving at full is still kept.
    assign pop  = grant_r;
    assign push = bus.r_we && (!full || pop);

    always_ff @(posedge CLK_VIDEO) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: bus.r_addr, din: bus.r_din, be: bus.r_be};
        end
    end

    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
            if (bus.r_we && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge CLK_VIDEO or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= G_CLIENT;
            cur_client <= 1'b0;
            cmd_addr   <= '0;
            cmd_din    <= '0;
            cmd_be     <= '0;
            cmd_we     <= 1'b0;
            cmd_rd     <= 1'b0;
            ack        <= 1'b0;
            dout       <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_r) begin
                        cmd_addr   <= head.addr;
                        cmd_din    <= head.din;
                        cmd_be     <= head.be;
                        cmd_we     <= 1'b1;
                        cmd_rd     <= 1'b0;
                        cur_client <= 1'b0;
                        last_grant <= G_ROTATE;
                        state      <= ISSUE;
                    end else if (grant_c) begin
                        cmd_addr   <= bus.c_addr;
                        cmd_din    <= bus.c_din;
                        cmd_be     <= bus.c_be;
                        cmd_we     <= !bus.c_rd;
                        cmd_rd     <= bus.c_rd;
                        cur_client <= 1'b1;
                        last_grant <= G_CLIENT;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.DDRAM_BUSY) begin
                        if (cmd_rd) begin
                            cmd_rd <= 1'b0;
                            state  <= RDWAIT;
                        end else begin
                            cmd_we <= 1'b0;
                            ack    <= cur_client;
                            state  <= IDLE;
                        end
                    end
                end
                RDWAIT: begin
                    if (bus.DDRAM_DOUT_READY) begin
                        dout  <= bus.DDRAM_DOUT;
                        ack   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.DDRAM_CLK      = CLK_VIDEO;
    assign bus.DDRAM_BURSTCNT = 8'd1;
    assign bus.DDRAM_ADDR     = cmd_addr;
    assign bus.DDRAM_DIN      = cmd_din;
    assign bus.DDRAM_BE       = cmd_be;
    assign bus.DDRAM_WE       = cmd_we;
    assign bus.DDRAM_RD       = cmd_rd;
    assign bus.c_ack          = ack;
    assign bus.c_dout         = dout;
    assign bus.r_overflow     = overflow;
    assign dbg_state          = state;

endmodule

// File: tb/tb_ddram_wr_arbiter.sv
// Directed bench for ddram_wr_arbiter: DDRAM command log checked against an expected
// queue, plus cycle-exact checks of latency, hold-under-busy, ack and reset behaviour.
module tb_ddram_wr_arbiter;
    typedef struct packed {
        logic        rd;
        logic [28:0] addr;
        logic [63:0] din;
        logic [7:0]  be;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         cyc = 0;

    ddram_wr_arbiter_if bus ();

    ddram_wr_arbiter #(.FIFO_AW(4), .URGENT(8)) dut (
        .CLK_VIDEO (clk),
        .reset     (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int   pass_cnt = 0;
    int   chk_cnt  = 0;
    int   both_cnt = 0;
    int   ack_cnt  = 0;
    cmd_t log_q[$];
    int   log_cyc[$];
    logic [101:0] exp_q[$];

    function automatic cmd_t mk(input logic rd, input logic [28:0] a, input logic [63:0] d,
                                input logic [7:0] b);
        cmd_t c;
        c.rd = rd; c.addr = a; c.din = d; c.be = b;
        return c;
    endfunction

    // Command monitor: records every accepted DDRAM command.
    always @(negedge clk) begin
        if (bus.DDRAM_WE && bus.DDRAM_RD) both_cnt++;
        if ((bus.DDRAM_WE || bus.DDRAM_RD) && !bus.DDRAM_BUSY) begin
            log_q.push_back(mk(bus.DDRAM_RD, bus.DDRAM_ADDR, bus.DDRAM_DIN, bus.DDRAM_BE));
            log_cyc.push_back(cyc);
        end
        if (bus.c_ack) ack_cnt++;
    end

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        chk_cnt++;
        assert (observed === expected) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_check(input string tag);
        check({tag, "_count"}, 128'(log_q.size()), 128'(exp_q.size()));
        while (exp_q.size() > 0 && log_q.size() > 0) begin
            check(tag, 128'(log_q.pop_front()), 128'(exp_q.pop_front()));
        end
        exp_q.delete();
        log_q.delete();
        log_cyc.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        @(negedge clk);
        check({tag, "_we"},       128'(bus.DDRAM_WE), 128'(0));
        check({tag, "_rd"},       128'(bus.DDRAM_RD), 128'(0));
        check({tag, "_cmd"},      128'({bus.DDRAM_ADDR, bus.DDRAM_DIN, bus.DDRAM_BE}), 128'(0));
        check({tag, "_burstcnt"}, 128'(bus.DDRAM_BURSTCNT), 128'(1));
        check({tag, "_ack"},      128'(bus.c_ack), 128'(0));
        check({tag, "_dout"},     128'(bus.c_dout), 128'(0));
        check({tag, "_overflow"}, 128'(bus.r_overflow), 128'(0));
        check({tag, "_state"},    128'(dbg_state), 128'(0));
        check({tag, "_ddram_clk"}, 128'(bus.DDRAM_CLK), 128'(clk));
    endtask

    // Waits (bounded) for c_ack, then drops c_req the cycle after it.
    task automatic wait_ack(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (bus.c_ack) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check(tag, 128'(seen), 128'(1));
        tick();
        bus.c_req = 1'b0;
    endtask

    initial begin
        int n0;
        int acks0;
        int logs0;

        // Clock/reset
        rst = 1'b1;
        bus.r_we = 1'b0; bus.r_addr = '0; bus.r_din = '0; bus.r_be = '0;
        bus.c_req = 1'b0; bus.c_rd = 1'b0; bus.c_addr = '0; bus.c_din = '0; bus.c_be = '0;
        bus.DDRAM_BUSY = 1'b0; bus.DDRAM_DOUT = '0; bus.DDRAM_DOUT_READY = 1'b0;
        tick(2);
        check_idle_outputs("reset");
        tick();
        rst = 1'b0;
        tick();

        // Test 1: four rotate writes, BUSY low; first WE two cycles after r_we
        n0 = cyc;
        for (int i = 0; i < 4; i++) begin
            bus.r_we   = 1'b1;
            bus.r_addr = 29'(i);
            bus.r_din  = {32'hA5A5_0000, 32'(i)};
            bus.r_be   = 8'hF0 | 8'(i);
            exp_q.push_back(mk(1'b0, 29'(i), {32'hA5A5_0000, 32'(i)}, 8'hF0 | 8'(i)));
            tick();
        end
        bus.r_we = 1'b0;
        tick(12);
        check("t1_first_latency", 128'(log_cyc[0]), 128'(n0 + 2));
        check("t1_spacing", 128'(log_cyc[3] - log_cyc[0]), 128'(6));
        sb_check("t1");

        // Test 2: command held stable while BUSY for 10 cycles, accepted once
        bus.DDRAM_BUSY = 1'b1;
        bus.r_we   = 1'b1;
        bus.r_addr = 29'h0ABC_DEF0;
        bus.r_din  = 64'hDEAD_BEEF_0123_4567;
        bus.r_be   = 8'h5A;
        exp_q.push_back(mk(1'b0, 29'h0ABC_DEF0, 64'hDEAD_BEEF_0123_4567, 8'h5A));
        tick();
        bus.r_we = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t2_hold", 128'({bus.DDRAM_WE, bus.DDRAM_ADDR, bus.DDRAM_DIN, bus.DDRAM_BE}),
                  128'({1'b1, 29'h0ABC_DEF0, 64'hDEAD_BEEF_0123_4567, 8'h5A}));
            tick();
        end
        bus.DDRAM_BUSY = 1'b0;
        tick(4);
        @(negedge clk);
        check("t2_we_dropped", 128'(bus.DDRAM_WE), 128'(0));
        sb_check("t2");

        // Test 3: from reset (last grant = client), rotate and client read alternate
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick();
        acks0 = ack_cnt;
        bus.r_we = 1'b1; bus.r_addr = 29'h10; bus.r_din = 64'h10; bus.r_be = 8'hFF;
        tick();
        bus.r_addr = 29'h11; bus.r_din = 64'h11;
        bus.c_req = 1'b1; bus.c_rd = 1'b1; bus.c_addr = 29'h100; bus.c_din = '0; bus.c_be = 8'hFF;
        tick();
        bus.r_addr = 29'h12; bus.r_din = 64'h12;
        tick();
        bus.r_we = 1'b0;
        tick(2);
        @(negedge clk);
        check("t3_rdwait_state", 128'(dbg_state), 128'(2));
        tick();
        bus.DDRAM_DOUT = 64'hCAFE_F00D_1234_5678;
        bus.DDRAM_DOUT_READY = 1'b1;
        tick();
        bus.DDRAM_DOUT_READY = 1'b0;
        @(negedge clk);
        check("t3_ack", 128'(bus.c_ack), 128'(1));
        check("t3_dout", 128'(bus.c_dout), 128'(64'hCAFE_F00D_1234_5678));
        tick();
        bus.c_req = 1'b0;
        @(negedge clk);
        check("t3_ack_pulse", 128'(bus.c_ack), 128'(0));
        tick(10);
        check("t3_ack_count", 128'(ack_cnt - acks0), 128'(1));
        exp_q.push_back(mk(1'b0, 29'h10, 64'h10, 8'hFF));
        exp_q.push_back(mk(1'b1, 29'h100, 64'h0, 8'hFF));
        exp_q.push_back(mk(1'b0, 29'h11, 64'h11, 8'hFF));
        exp_q.push_back(mk(1'b0, 29'h12, 64'h12, 8'hFF));
        sb_check("t3");

        // Test 4: client write stuck under BUSY, 17 rotate writes -> 16 kept, overflow
        acks0 = ack_cnt;
        bus.DDRAM_BUSY = 1'b1;
        bus.c_req = 1'b1; bus.c_rd = 1'b0; bus.c_addr = 29'h300;
        bus.c_din = 64'h3333_4444_5555_6666; bus.c_be = 8'h81;
        exp_q.push_back(mk(1'b0, 29'h300, 64'h3333_4444_5555_6666, 8'h81));
        tick();
        for (int i = 0; i < 17; i++) begin
            bus.r_we   = 1'b1;
            bus.r_addr = 29'h200 + 29'(i);
            bus.r_din  = 64'hB000 + 64'(i);
            bus.r_be   = 8'(i);
            if (i < 16) exp_q.push_back(mk(1'b0, 29'h200 + 29'(i), 64'hB000 + 64'(i), 8'(i)));
            if (i == 16) begin
                @(negedge clk);
                check("t4_overflow_before_drop", 128'(bus.r_overflow), 128'(0));
            end
            tick();
        end
        bus.r_we = 1'b0;
        @(negedge clk);
        check("t4_overflow_set", 128'(bus.r_overflow), 128'(1));
        check("t4_stuck_issue", 128'(dbg_state), 128'(1));
        tick();
        bus.DDRAM_BUSY = 1'b0;
        wait_ack("t4_client_write_ack");
        tick(40);
        @(negedge clk);
        check("t4_overflow_sticky", 128'(bus.r_overflow), 128'(1));
        check("t4_ack_count", 128'(ack_cnt - acks0), 128'(1));
        sb_check("t4");

        // Test 5: fill >= 8 keeps the client waiting until the FIFO drops below 8
        bus.DDRAM_BUSY = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.r_we   = 1'b1;
            bus.r_addr = 29'h400 + 29'(i);
            bus.r_din  = 64'hC000 + 64'(i);
            bus.r_be   = 8'h3C;
            tick();
        end
        bus.r_we = 1'b0;
        bus.c_req = 1'b1; bus.c_rd = 1'b0; bus.c_addr = 29'h500;
        bus.c_din = 64'h5555_0000_AAAA_FFFF; bus.c_be = 8'hC3;
        tick();
        bus.DDRAM_BUSY = 1'b0;
        wait_ack("t5_client_ack");
        tick(30);
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 29'h400 + 29'(i), 64'hC000 + 64'(i), 8'h3C));
        exp_q.push_back(mk(1'b0, 29'h500, 64'h5555_0000_AAAA_FFFF, 8'hC3));
        for (int i = 3; i < 10; i++) exp_q.push_back(mk(1'b0, 29'h400 + 29'(i), 64'hC000 + 64'(i), 8'h3C));
        sb_check("t5");

        // Test 6: reset while waiting for read data; late DOUT_READY must be ignored
        acks0 = ack_cnt;
        bus.c_req = 1'b1; bus.c_rd = 1'b1; bus.c_addr = 29'h600; bus.c_din = '0; bus.c_be = 8'hFF;
        tick(3);
        for (int i = 0; i < 3; i++) begin
            bus.r_we   = 1'b1;
            bus.r_addr = 29'h700 + 29'(i);
            bus.r_din  = 64'hD000 + 64'(i);
            bus.r_be   = 8'hFF;
            tick();
        end
        bus.r_we = 1'b0;
        @(negedge clk);
        check("t6_rdwait_state", 128'(dbg_state), 128'(2));
        check("t6_no_cmd_in_rdwait", 128'(log_q.size()), 128'(1));
        logs0 = log_q.size();
        tick();
        rst = 1'b1;
        bus.c_req = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        bus.DDRAM_DOUT = 64'h0BAD_0BAD_0BAD_0BAD;
        bus.DDRAM_DOUT_READY = 1'b1;
        tick();
        bus.DDRAM_DOUT_READY = 1'b0;
        tick(8);
        check_idle_outputs("t6_after_reset");
        check("t6_no_ack", 128'(ack_cnt - acks0), 128'(0));
        check("t6_fifo_flushed", 128'(log_q.size()), 128'(logs0));
        exp_q.push_back(mk(1'b1, 29'h600, 64'h0, 8'hFF));
        sb_check("t6");

        check("we_rd_exclusive", 128'(both_cnt), 128'(0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
